// File: rtl/rx_comma_aligner.sv
// Receive-side K28.5 symbol aligner: hunts for commas in the serial bit stream, locks
// after repeated aligned commas, and packs aligned 10b symbols into SYMS-wide words.
module rx_comma_aligner #(
    parameter int SYMS        = 4,
    parameter int LOCK_COMMAS = 3,
    parameter int UNLOCK_ERRS = 4,
    parameter int ALIGN_WORD  = 1
) (
    input  logic                 clkRx,
    input  logic                 rst,
    input  logic                 enb,
    input  logic                 serialIn,
    output logic [9:0]           sym_out,
    output logic                 sym_valid,
    output logic                 sym_comma,
    output logic [10*SYMS-1:0]   word_out,
    output logic                 word_valid,
    output logic [SYMS-1:0]      word_k,
    output logic                 locked,
    output logic                 code_err,
    output logic                 word_drop
);

    localparam int IDXW = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam int CCW  = $clog2(LOCK_COMMAS + 1);
    localparam int ECW  = $clog2(UNLOCK_ERRS + 1);

    localparam logic [9:0] kCommaNeg = 10'b0011111010;
    localparam logic [9:0] kCommaPos = 10'b1100000101;

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} alignState_t;

    alignState_t          state;
    logic [9:0]           shiftReg;
    logic [3:0]           phase;
    logic [CCW-1:0]       commaCnt;
    logic [ECW-1:0]       errCnt;
    logic [IDXW-1:0]      slotIdx;
    logic [10*SYMS-1:0]   accWord;
    logic [SYMS-1:0]      accK;

    logic [9:0]           window;
    logic [3:0]           ones;
    logic                 isComma;
    logic                 isInvalid;
    logic                 atBoundary;
    logic                 reachLock;
    logic                 emitNow;
    logic                 realign;
    logic [IDXW-1:0]      slot;
    logic                 lastSlot;
    logic                 unlockNow;
    logic [10*SYMS-1:0]   accWordNext;
    logic [SYMS-1:0]      accKNext;

    always_comb begin
        window = {shiftReg[8:0], serialIn};
        ones = '0;
        for (int unsigned b = 0; b < 10; b++) begin
            ones = ones + 4'(window[b]);
        end
        isComma    = (window == kCommaNeg) || (window == kCommaPos);
        isInvalid  = (ones < 4'd4) || (ones > 4'd6) ||
                     (&window[9:4]) || (~|window[9:4]) ||
                     (&window[3:0]) || (~|window[3:0]);
        atBoundary = (phase == 4'd9);
        reachLock  = (LOCK_COMMAS <= 1) || (commaCnt == CCW'(LOCK_COMMAS - 1));
        emitNow    = enb && (((state == HUNT) && isComma && (LOCK_COMMAS == 1)) ||
                             ((state == CHECK) && atBoundary && isComma && reachLock) ||
                             ((state == LOCKED) && atBoundary));
        // Only a comma landing mid-word is pulled back to slot 0.
        realign    = (ALIGN_WORD != 0) && isComma && (slotIdx != '0);
        slot       = realign ? '0 : slotIdx;
        lastSlot   = (slot == IDXW'(SYMS - 1));
        unlockNow  = (state == LOCKED) && atBoundary && isInvalid &&
                     (errCnt == ECW'(UNLOCK_ERRS - 1));
        accWordNext = accWord;
        accKNext    = accK;
        for (int unsigned s = 0; s < SYMS; s++) begin
            if (slot == IDXW'(s)) begin
                accWordNext[10*s +: 10] = window;
                accKNext[s]             = isComma;
            end
        end
    end

    always_ff @(posedge clkRx or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            shiftReg   <= '0;
            phase      <= '0;
            commaCnt   <= '0;
            errCnt     <= '0;
            slotIdx    <= '0;
            accWord    <= '0;
            accK       <= '0;
            sym_out    <= '0;
            sym_valid  <= 1'b0;
            sym_comma  <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
            word_k     <= '0;
            locked     <= 1'b0;
            code_err   <= 1'b0;
            word_drop  <= 1'b0;
        end else begin
            sym_valid  <= 1'b0;
            sym_comma  <= 1'b0;
            word_valid <= 1'b0;
            code_err   <= 1'b0;
            word_drop  <= 1'b0;
            if (enb) begin
                shiftReg <= window;
                if (state != HUNT) begin
                    phase <= atBoundary ? 4'd0 : phase + 4'd1;
                end
                if (emitNow) begin
                    sym_out   <= window;
                    sym_valid <= 1'b1;
                    sym_comma <= isComma;
                    accWord   <= accWordNext;
                    accK      <= accKNext;
                    word_drop <= realign;
                    if (lastSlot) begin
                        word_out   <= accWordNext;
                        word_k     <= accKNext;
                        word_valid <= 1'b1;
                        slotIdx    <= '0;
                    end else begin
                        slotIdx <= slot + IDXW'(1);
                    end
                end
                case (state)
                    HUNT: begin
                        if (isComma) begin
                            phase    <= '0;
                            commaCnt <= CCW'(1);
                            errCnt   <= '0;
                            if (LOCK_COMMAS == 1) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (atBoundary) begin
                            if (isComma) begin
                                commaCnt <= commaCnt + CCW'(1);
                                if (reachLock) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                    errCnt <= '0;
                                end
                            end else if (isInvalid) begin
                                code_err <= 1'b1;
                                state    <= HUNT;
                            end
                        end
                    end
                    LOCKED: begin
                        if (atBoundary) begin
                            if (isInvalid) begin
                                code_err <= 1'b1;
                                errCnt   <= errCnt + ECW'(1);
                                // Unlock overrides the slot advance so the next lock packs from slot 0.
                                if (unlockNow) begin
                                    state   <= HUNT;
                                    locked  <= 1'b0;
                                    slotIdx <= '0;
                                end
                            end else begin
                                errCnt <= '0;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule
